log_pow2_pipe: RTL and testbench
================================

LOG_POW2_PIPE -- requirements
Module: log_pow2_pipe

Interface
REQ-001 Parameter INT_WIDTH, default 6: signed integer bits of the log input and of the output exponent.
REQ-002 Parameter FRAC_WIDTH, default 8: fraction bits of the log input and output mantissa; the only supported value is 8.
REQ-003 clock  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  input word present.
REQ-006 in_ready  output  1  block accepts the input word this cycle.
REQ-007 in_log  input  INT_WIDTH+8  signed fixed-point log2 value: upper INT_WIDTH bits are the integer part, low 8 bits the fraction.
REQ-008 in_zero  input  1  sideband flag for a linear zero; carried through unchanged.
REQ-009 out_valid  output  1  output word present.
REQ-010 out_ready  input  1  downstream accepts the output word.
REQ-011 out_exp  output  INT_WIDTH  signed exponent, equal to the integer part of in_log.
REQ-012 out_mant  output  8  linear mantissa fraction with an implicit leading 1.
REQ-013 out_zero  output  1  delayed copy of in_zero.

Function
REQ-014 Delta table T[0..15] (5-bit, unsigned) SHALL be 0,27,23,20,16,14,12,11,10,10,11,12,15,18,22,26, indexed by f[7:4], where f = in_log[7:0].
REQ-015 Without interpolation, delta = T[f[7:4]].
REQ-016 out_mant = f - delta when f >= delta, else 0; the computation is 9-bit signed, clamped at 0, with no wrap.
REQ-017 Two register stages: S1 captures the inputs and the table lookup(s); S2 captures the corrected result. Latency is 2 cycles from an accepting in_valid&&in_ready edge to out_valid; throughput is 1 word/cycle.
REQ-018 Enables: en2 = out_ready | !v2; en1 = en2 | !v1; in_ready = en1. There is no combinational path from in_valid to out_valid.
REQ-019 Register behaviour when a stage enable is low:
- S2 holds out_* stable while out_valid && !out_ready.
- Bubbles in S1 or S2 collapse; a word is never duplicated or dropped.
REQ-020 When a word leaves S2 in the same cycle a new word enters S1, both transfers SHALL occur.
REQ-021 out_exp and out_zero are pure pipeline copies; out_mant is computed regardless of in_zero.

Reset
REQ-022 Reset asserted SHALL asynchronously clear v1, v2, out_valid, out_exp, out_mant and out_zero to 0.
REQ-023 Reset mid-operation SHALL discard all in-flight words.
REQ-024 in_ready SHALL be 1 from the first cycle after reset deasserts.

Configuration
REQ-025 Macro LOG_POW2_INTERP_EN defined: delta = T[i] + floor(((T[j] - T[i]) * f[3:0]) / 16), with i = f[7:4], j = (i+1) mod 16 (T[0] wraps for i=15), computed signed with an arithmetic shift.
REQ-026 With LOG_POW2_INTERP_EN defined, the second lookup and the multiply occur in S1, and latency stays 2.
REQ-027 Macro undefined: REQ-015 applies, and the second lookup and multiplier are absent.

Structure
REQ-028 Shared package log_pow2_pkg holds FRAC_WIDTH=8, the index width 4, the delta width 5, and the packed S1/S2 stage-record typedefs.
REQ-029 The table is one sub-module, pow2_delta_table (4-bit index in, 5-bit delta out, combinational). It is instantiated once, or twice under LOG_POW2_INTERP_EN.

Verification
REQ-030 Basic lookup:
- Stimulus: in_log int=3, f=0x80, out_ready=1.
- Response: out_exp=3, out_mant=0x76 (0x80-10), two cycles after acceptance.
REQ-031 Clamp at zero:
- Stimulus: f=0x10.
- Response: out_mant=0x00 (16-27 clamped).
- Also: f=0x00 -> out_mant=0x00; in_zero=1 -> out_zero=1.
REQ-032 Interpolation:
- Macro off: f=0xF8 -> out_mant=0xDE.
- LOG_POW2_INTERP_EN: f=0xF8 -> out_mant=0xEB (delta 13); f=0x88 -> out_mant=0x7E.
REQ-033 Backpressure:
- Stimulus: stream 5 words with out_ready=0 for 4 cycles.
- Response: in_ready drops after 2 accepted; out_* stable throughout; all 5 words emerge in order once out_ready=1.
REQ-034 Full throughput: in_valid=1 and out_ready=1 continuously -> one output per cycle, with in_ready constantly 1.
REQ-035 Reset mid-stream: reset with 2 words in flight -> out_valid=0 immediately, and no stale word appears after reset deasserts.

Source files
------------

// File: rtl/log_pow2_pkg.sv
// Shared constants and stage records for the log2-to-linear pipeline.
// The table and the pipeline both assume an 8-bit fraction.
package log_pow2_pkg;

   localparam int FRAC_WIDTH  = 8;
   localparam int IDX_WIDTH   = 4;
   localparam int DELTA_WIDTH = 5;

   // Stage 1 holds the raw fraction alongside the delta it selected.
   typedef struct packed {
      logic [FRAC_WIDTH-1:0]  frac;
      logic [DELTA_WIDTH-1:0] delta;
      logic                   zero;
   } s1_rec_t;

   typedef struct packed {
      logic [FRAC_WIDTH-1:0] mant;
      logic                  zero;
   } s2_rec_t;

   // Mantissa correction: a small f with a large delta must floor at 0, never wrap.
   function automatic logic [FRAC_WIDTH-1:0] clamp_sub(input logic [FRAC_WIDTH-1:0]  f,
                                                       input logic [DELTA_WIDTH-1:0] d);
      logic signed [FRAC_WIDTH:0] diff;
      diff = $signed({1'b0, f}) - $signed({{(FRAC_WIDTH-DELTA_WIDTH+1){1'b0}}, d});
      return (diff < 0) ? '0 : diff[FRAC_WIDTH-1:0];
   endfunction

endpackage

// File: rtl/log_pow2_if.sv
// Valid/ready bus for the log2-to-linear pipeline: log word in, exponent and mantissa out.
interface log_pow2_if #(
   parameter int INT_WIDTH = 6
);
   logic                                               in_valid;
   logic                                               in_ready;
   logic [INT_WIDTH+log_pow2_pkg::FRAC_WIDTH-1:0]      in_log;
   logic                                               in_zero;
   logic                                               out_valid;
   logic                                               out_ready;
   logic signed [INT_WIDTH-1:0]                        out_exp;
   logic [log_pow2_pkg::FRAC_WIDTH-1:0]                out_mant;
   logic                                               out_zero;

   modport master (
      output in_valid, in_log, in_zero, out_ready,
      input  in_ready, out_valid, out_exp, out_mant, out_zero
   );

   modport slave (
      input  in_valid, in_log, in_zero, out_ready,
      output in_ready, out_valid, out_exp, out_mant, out_zero
   );
endinterface

// File: rtl/pow2_delta_table.sv
// Piecewise correction table for 2^f approximated as 1+f: delta per 1/16 segment of the fraction.
module pow2_delta_table
   import log_pow2_pkg::*;
(
   input  logic [IDX_WIDTH-1:0]   idx,
   output logic [DELTA_WIDTH-1:0] delta
);

   always_comb begin
      delta = '0;
      case (idx)
         4'd0:    delta = 5'd0;
         4'd1:    delta = 5'd27;
         4'd2:    delta = 5'd23;
         4'd3:    delta = 5'd20;
         4'd4:    delta = 5'd16;
         4'd5:    delta = 5'd14;
         4'd6:    delta = 5'd12;
         4'd7:    delta = 5'd11;
         4'd8:    delta = 5'd10;
         4'd9:    delta = 5'd10;
         4'd10:   delta = 5'd11;
         4'd11:   delta = 5'd12;
         4'd12:   delta = 5'd15;
         4'd13:   delta = 5'd18;
         4'd14:   delta = 5'd22;
         4'd15:   delta = 5'd26;
         default: delta = 5'd0;
      endcase
   end

endmodule

// File: rtl/log_pow2_pipe.sv
// Two-stage log2 -> (exponent, mantissa) converter with valid/ready flow control.
// Define LOG_POW2_INTERP_EN to linearly interpolate between adjacent table entries.
module log_pow2_pipe #(
   parameter int INT_WIDTH  = 6,
   parameter int FRAC_WIDTH = 8
) (
   input logic        clock,
   input logic        reset,
   log_pow2_if.slave  bus
);
   import log_pow2_pkg::*;

   logic                        v1, v2;
   logic                        en1, en2;
   s1_rec_t                     s1;
   s2_rec_t                     s2;
   logic signed [INT_WIDTH-1:0] s1_exp, s2_exp;

   logic [FRAC_WIDTH-1:0]       f;
   logic [IDX_WIDTH-1:0]        idx_lo;
   logic [DELTA_WIDTH-1:0]      t_lo;
   logic [DELTA_WIDTH-1:0]      delta_in;

   // A stage may load when it is empty or when the stage after it is moving.
   assign en2          = bus.out_ready | ~v2;
   assign en1          = en2 | ~v1;
   assign bus.in_ready = en1;

   assign f      = bus.in_log[FRAC_WIDTH-1:0];
   assign idx_lo = f[FRAC_WIDTH-1 -: IDX_WIDTH];

   pow2_delta_table u_table_lo (
      .idx   (idx_lo),
      .delta (t_lo)
   );

`ifdef LOG_POW2_INTERP_EN
   logic [IDX_WIDTH-1:0]      idx_hi;
   logic [DELTA_WIDTH-1:0]    t_hi;
   logic signed [10:0]        slope;
   logic signed [10:0]        prod;
   logic signed [10:0]        step;
   logic signed [10:0]        sum;

   // Segment 15 interpolates back toward entry 0; the 4-bit increment wraps naturally.
   assign idx_hi = idx_lo + 4'd1;

   pow2_delta_table u_table_hi (
      .idx   (idx_hi),
      .delta (t_hi)
   );

   assign slope    = $signed({6'b0, t_hi}) - $signed({6'b0, t_lo});
   assign prod     = slope * $signed({7'b0, f[3:0]});
   assign step     = prod >>> 4;
   assign sum      = $signed({6'b0, t_lo}) + step;
   assign delta_in = sum[DELTA_WIDTH-1:0];
`else
   assign delta_in = t_lo;
`endif

   // Stage 1: capture the word together with its looked-up delta.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         v1     <= 1'b0;
         s1     <= '0;
         s1_exp <= '0;
      end else if (en1) begin
         v1       <= bus.in_valid;
         s1.frac  <= f;
         s1.delta <= delta_in;
         s1.zero  <= bus.in_zero;
         s1_exp   <= bus.in_log[INT_WIDTH+FRAC_WIDTH-1:FRAC_WIDTH];
      end
   end

   // Stage 2: apply the correction; holding en2 low freezes the presented word.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         v2     <= 1'b0;
         s2     <= '0;
         s2_exp <= '0;
      end else if (en2) begin
         v2      <= v1;
         s2.mant <= clamp_sub(s1.frac, s1.delta);
         s2.zero <= s1.zero;
         s2_exp  <= s1_exp;
      end
   end

   assign bus.out_valid = v2;
   assign bus.out_exp   = s2_exp;
   assign bus.out_mant  = s2.mant;
   assign bus.out_zero  = s2.zero;

endmodule

// File: tb/tb_log_pow2_pipe.sv
// Directed-vector bench for log_pow2_pipe: table of single words, then
// backpressure, full-throughput and mid-stream reset sequences.
module tb_log_pow2_pipe;

   typedef struct {
      logic signed [5:0] ip;
      logic [7:0]        frac;
      logic              zero;
      logic signed [5:0] expExp;
      logic [7:0]        expMant;
      logic              expZero;
   } vec_t;

   localparam int NVEC = 13;

   logic clk;
   logic rst;
   int   nApplied;
   int   nMiss;
   vec_t vecs[NVEC];

   log_pow2_if #(.INT_WIDTH(6)) bus ();

   log_pow2_pipe #(.INT_WIDTH(6), .FRAC_WIDTH(8)) dut (
      .clock (clk),
      .reset (rst),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      nApplied++;
      if (actual !== expected) begin
         nMiss++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   function automatic logic [31:0] packOut();
      return {17'b0, bus.out_exp, bus.out_mant, bus.out_zero};
   endfunction

   function automatic logic [31:0] packExp(input int i);
      return {17'b0, vecs[i].expExp, vecs[i].expMant, vecs[i].expZero};
   endfunction

   task automatic driveWord(input int i, input int limit);
      if (i < limit) begin
         bus.in_log   = {vecs[i].ip, vecs[i].frac};
         bus.in_zero  = vecs[i].zero;
         bus.in_valid = 1'b1;
      end else begin
         bus.in_valid = 1'b0;
      end
   endtask

   // One isolated word: wait for acceptance, then measure latency and compare.
   task automatic applyStimulus(input int idx);
      bit accepted;
      bit seen;
      int lat;
      driveWord(idx, NVEC);
      bus.out_ready = 1'b1;
      accepted = 1'b0;
      for (int c = 0; c < 8 && !accepted; c++) begin
         @(negedge clk);
         accepted = bus.in_ready;
         @(posedge clk);
         #1;
      end
      bus.in_valid = 1'b0;
      checkOutput($sformatf("vec%0d_accept", idx), {31'b0, accepted}, 32'd1);
      seen = 1'b0;
      lat  = 1;
      for (int c = 0; c < 8 && !seen; c++) begin
         @(negedge clk);
         if (bus.out_valid) seen = 1'b1;
         else begin
            @(posedge clk);
            #1;
            lat++;
         end
      end
      checkOutput($sformatf("vec%0d_latency", idx), lat, 32'd2);
      checkOutput($sformatf("vec%0d_out", idx), packOut(), packExp(idx));
      @(posedge clk);
      #1;
   endtask

   initial begin
      int sent, got, stableErr, stale, gap, firstOut;
      bit held, lastReady;
      logic [31:0] snap;

      nApplied = 0;
      nMiss    = 0;

      //                ip    frac   z   exp   mant    z
      vecs[0]  = '{ 6'sd3,   8'h80, 1'b0, 6'sd3,   8'h76, 1'b0};
      vecs[1]  = '{ 6'sd3,   8'h10, 1'b0, 6'sd3,   8'h00, 1'b0};
      vecs[2]  = '{-6'sd2,   8'h00, 1'b1, -6'sd2,  8'h00, 1'b1};
`ifdef LOG_POW2_INTERP_EN
      vecs[3]  = '{ 6'sd5,   8'hF8, 1'b0, 6'sd5,   8'hEB, 1'b0};
      vecs[4]  = '{-6'sd7,   8'h88, 1'b0, -6'sd7,  8'h7E, 1'b0};
      vecs[5]  = '{ 6'sd31,  8'hFF, 1'b0, 6'sd31,  8'hFE, 1'b0};
      vecs[6]  = '{-6'sd32,  8'h1F, 1'b1, -6'sd32, 8'h08, 1'b1};
      vecs[7]  = '{ 6'sd0,   8'h24, 1'b0, 6'sd0,   8'h0E, 1'b0};
      vecs[8]  = '{ 6'sd1,   8'h5A, 1'b1, 6'sd1,   8'h4E, 1'b1};
      vecs[9]  = '{-6'sd1,   8'hC3, 1'b0, -6'sd1,  8'hB4, 1'b0};
      vecs[10] = '{ 6'sd12,  8'h9C, 1'b0, 6'sd12,  8'h92, 1'b0};
      vecs[11] = '{-6'sd20,  8'h6F, 1'b1, -6'sd20, 8'h64, 1'b1};
      vecs[12] = '{ 6'sd7,   8'h0F, 1'b0, 6'sd7,   8'h00, 1'b0};
`else
      vecs[3]  = '{ 6'sd5,   8'hF8, 1'b0, 6'sd5,   8'hDE, 1'b0};
      vecs[4]  = '{-6'sd7,   8'h88, 1'b0, -6'sd7,  8'h7E, 1'b0};
      vecs[5]  = '{ 6'sd31,  8'hFF, 1'b0, 6'sd31,  8'hE5, 1'b0};
      vecs[6]  = '{-6'sd32,  8'h1F, 1'b1, -6'sd32, 8'h04, 1'b1};
      vecs[7]  = '{ 6'sd0,   8'h24, 1'b0, 6'sd0,   8'h0D, 1'b0};
      vecs[8]  = '{ 6'sd1,   8'h5A, 1'b1, 6'sd1,   8'h4C, 1'b1};
      vecs[9]  = '{-6'sd1,   8'hC3, 1'b0, -6'sd1,  8'hB4, 1'b0};
      vecs[10] = '{ 6'sd12,  8'h9C, 1'b0, 6'sd12,  8'h92, 1'b0};
      vecs[11] = '{-6'sd20,  8'h6F, 1'b1, -6'sd20, 8'h63, 1'b1};
      vecs[12] = '{ 6'sd7,   8'h0F, 1'b0, 6'sd7,   8'h0F, 1'b0};
`endif

      // Reset state
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_log    = '0;
      bus.in_zero   = 1'b0;
      bus.out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_out_valid", {31'b0, bus.out_valid}, 32'd0);
      checkOutput("reset_outputs", packOut(), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("reset_in_ready", {31'b0, bus.in_ready}, 32'd1);
      @(posedge clk);
      #1;

      $display("[TB] single-word vectors");
      for (int i = 0; i < NVEC; i++) applyStimulus(i);

      $display("[TB] backpressure sequence");
      sent = 0; got = 0; held = 1'b0; stableErr = 0; lastReady = 1'b1; snap = '0;
      bus.out_ready = 1'b0;
      for (int c = 0; c < 4; c++) begin
         driveWord(sent, 5);
         @(negedge clk);
         if (bus.out_valid) begin
            if (!held) begin
               held = 1'b1;
               snap = packOut();
            end else if (packOut() !== snap) stableErr++;
         end
         lastReady = bus.in_ready;
         if (bus.in_valid && bus.in_ready) sent++;
         @(posedge clk);
         #1;
      end
      checkOutput("bp_accepted", sent, 32'd2);
      checkOutput("bp_in_ready_low", {31'b0, lastReady}, 32'd0);
      checkOutput("bp_held_seen", {31'b0, held}, 32'd1);
      checkOutput("bp_stable", stableErr, 32'd0);
      checkOutput("bp_head_word", snap, packExp(0));
      bus.out_ready = 1'b1;
      for (int c = 0; c < 20 && got < 5; c++) begin
         driveWord(sent, 5);
         @(negedge clk);
         if (bus.out_valid) begin
            checkOutput($sformatf("bp_out%0d", got), packOut(), packExp(got));
            got++;
         end
         if (bus.in_valid && bus.in_ready) sent++;
         @(posedge clk);
         #1;
      end
      bus.in_valid = 1'b0;
      checkOutput("bp_count", got, 32'd5);
      repeat (3) @(posedge clk);
      #1;

      $display("[TB] full-throughput sequence");
      sent = 0; got = 0; gap = 0; firstOut = -1;
      bus.out_ready = 1'b1;
      for (int c = 0; c < NVEC + 10 && got < NVEC; c++) begin
         driveWord(sent, NVEC);
         @(negedge clk);
         if (sent < NVEC) checkOutput($sformatf("thru_in_ready_c%0d", c), {31'b0, bus.in_ready}, 32'd1);
         if (bus.out_valid) begin
            if (firstOut < 0) firstOut = c;
            checkOutput($sformatf("thru_out%0d", got), packOut(), packExp(got));
            got++;
         end else if (got > 0 && got < NVEC) gap++;
         if (bus.in_valid && bus.in_ready) sent++;
         @(posedge clk);
         #1;
      end
      bus.in_valid = 1'b0;
      checkOutput("thru_count", got, NVEC);
      checkOutput("thru_first_cycle", firstOut, 32'd2);
      checkOutput("thru_gaps", gap, 32'd0);
      repeat (3) @(posedge clk);
      #1;

      $display("[TB] reset mid-stream sequence");
      sent = 0;
      bus.out_ready = 1'b0;
      for (int c = 0; c < 2; c++) begin
         driveWord(sent, 2);
         @(negedge clk);
         if (bus.in_valid && bus.in_ready) sent++;
         @(posedge clk);
         #1;
      end
      bus.in_valid = 1'b0;
      checkOutput("rst_inflight", sent, 32'd2);
      checkOutput("rst_pre_valid", {31'b0, bus.out_valid}, 32'd1);
      #2 rst = 1'b1;
      #1;
      checkOutput("rst_async_valid", {31'b0, bus.out_valid}, 32'd0);
      checkOutput("rst_async_out", packOut(), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.out_ready = 1'b1;
      stale = 0;
      @(negedge clk);
      checkOutput("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (bus.out_valid) stale++;
      end
      checkOutput("rst_no_stale", stale, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nApplied, nMiss);
      $finish;
   end

endmodule
